// File: rtl/issue_sched.sv
// Dual-issue in-order issue scheduler: RAW readiness against EX1..EX3 writers,
// in-flight writer tracking, forwarding packets and registered operand selects.

package issue_sched_pkg;
    // Each select names the stage the producer occupies once the consumer sits in EX1.
    typedef enum logic [2:0] {
        FWD_NONE,
        FWD_EX2_I0,
        FWD_EX2_I1,
        FWD_EX3_I0,
        FWD_EX3_I1,
        FWD_WB_I0,
        FWD_WB_I1
    } fwd_src_t;

    typedef struct packed {
        logic       valid;
        logic [4:0] addr;
        logic [1:0] lat;
        logic       ready;
    } fwd_lane_t;

    typedef struct packed {
        fwd_lane_t i1;
        fwd_lane_t i0;
    } fwd_pkt_t;
endpackage

// Forwarding initiator for one source operand: youngest matching writer wins.
module fwd_init
    import issue_sched_pkg::*;
(
    input  logic [4:0] rs,
    input  fwd_pkt_t   ex1_p,
    input  fwd_pkt_t   ex2_p,
    input  fwd_pkt_t   ex3_p,
    output logic       rdy,
    output fwd_src_t   src
);
    logic unused_lat;
    assign unused_lat = ^{ex1_p.i0.lat, ex1_p.i1.lat, ex2_p.i0.lat,
                          ex2_p.i1.lat, ex3_p.i0.lat, ex3_p.i1.lat};

    always_comb begin
        rdy = 1'b1;
        src = FWD_NONE;
        if (rs != 5'd0) begin
            if (ex1_p.i1.valid && ex1_p.i1.addr == rs) begin
                rdy = ex1_p.i1.ready;
                src = FWD_EX2_I1;
            end else if (ex1_p.i0.valid && ex1_p.i0.addr == rs) begin
                rdy = ex1_p.i0.ready;
                src = FWD_EX2_I0;
            end else if (ex2_p.i1.valid && ex2_p.i1.addr == rs) begin
                rdy = ex2_p.i1.ready;
                src = FWD_EX3_I1;
            end else if (ex2_p.i0.valid && ex2_p.i0.addr == rs) begin
                rdy = ex2_p.i0.ready;
                src = FWD_EX3_I0;
            end else if (ex3_p.i1.valid && ex3_p.i1.addr == rs) begin
                rdy = ex3_p.i1.ready;
                src = FWD_WB_I1;
            end else if (ex3_p.i0.valid && ex3_p.i0.addr == rs) begin
                rdy = ex3_p.i0.ready;
                src = FWD_WB_I0;
            end
        end
    end
endmodule

module issue_sched
    import issue_sched_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i0_valid,
    input  logic             i1_valid,
    input  logic [4:0]       i0_rs1,
    input  logic [4:0]       i0_rs2,
    input  logic [4:0]       i0_rd,
    input  logic [4:0]       i1_rs1,
    input  logic [4:0]       i1_rs2,
    input  logic [4:0]       i1_rd,
    input  logic             i0_we,
    input  logic             i1_we,
    input  logic [1:0]       i0_lat,
    input  logic [1:0]       i1_lat,
    input  logic             ex_stall,
    input  logic             flush,
    output logic             issue_i0,
    output logic             issue_i1,
    output logic             bundle_done,
    output fwd_src_t         i0_rs1_src,
    output fwd_src_t         i0_rs2_src,
    output fwd_src_t         i1_rs1_src,
    output fwd_src_t         i1_rs2_src,
    output fwd_pkt_t         ex1_fwd_p,
    output fwd_pkt_t         ex2_fwd_p,
    output fwd_pkt_t         ex3_fwd_p,
    output logic [CNT_W-1:0] stall_cnt
);
    // Stage index 0..2 = EX1..EX3, lane index 0/1 = i0/i1.
    logic       st_valid [3][2];
    logic [4:0] st_addr  [3][2];
    logic [1:0] st_lat   [3][2];

    logic       pending;
    logic       go, i1_v, pair_raw;
    logic       rdy_01, rdy_02, rdy_11, rdy_12;
    fwd_src_t   src_01, src_02, src_11, src_12;
    logic       ins_valid [2];
    logic [4:0] ins_addr  [2];
    logic [1:0] ins_lat   [2];

    function automatic fwd_lane_t mk_lane(input logic v, input logic [4:0] a,
                                          input logic [1:0] l, input logic r);
        fwd_lane_t f;
        f.valid = v;
        f.addr  = a;
        f.lat   = l;
        f.ready = r;
        return f;
    endfunction

    // Stored latency is already clamped to 2, so EX2 readiness is simply lat < 2.
    always_comb begin
        ex1_fwd_p.i0 = mk_lane(st_valid[0][0], st_addr[0][0], st_lat[0][0], st_lat[0][0] == 2'd0);
        ex1_fwd_p.i1 = mk_lane(st_valid[0][1], st_addr[0][1], st_lat[0][1], st_lat[0][1] == 2'd0);
        ex2_fwd_p.i0 = mk_lane(st_valid[1][0], st_addr[1][0], st_lat[1][0], st_lat[1][0] < 2'd2);
        ex2_fwd_p.i1 = mk_lane(st_valid[1][1], st_addr[1][1], st_lat[1][1], st_lat[1][1] < 2'd2);
        ex3_fwd_p.i0 = mk_lane(st_valid[2][0], st_addr[2][0], st_lat[2][0], 1'b1);
        ex3_fwd_p.i1 = mk_lane(st_valid[2][1], st_addr[2][1], st_lat[2][1], 1'b1);
    end

    fwd_init u_fi_01 (.rs(i0_rs1), .ex1_p(ex1_fwd_p), .ex2_p(ex2_fwd_p), .ex3_p(ex3_fwd_p), .rdy(rdy_01), .src(src_01));
    fwd_init u_fi_02 (.rs(i0_rs2), .ex1_p(ex1_fwd_p), .ex2_p(ex2_fwd_p), .ex3_p(ex3_fwd_p), .rdy(rdy_02), .src(src_02));
    fwd_init u_fi_11 (.rs(i1_rs1), .ex1_p(ex1_fwd_p), .ex2_p(ex2_fwd_p), .ex3_p(ex3_fwd_p), .rdy(rdy_11), .src(src_11));
    fwd_init u_fi_12 (.rs(i1_rs2), .ex1_p(ex1_fwd_p), .ex2_p(ex2_fwd_p), .ex3_p(ex3_fwd_p), .rdy(rdy_12), .src(src_12));

    // i1 is meaningless without i0; the pair check keeps i1 off a same-bundle producer.
    always_comb begin
        go          = ~ex_stall & ~flush;
        i1_v        = i1_valid & i0_valid;
        pair_raw    = i0_we & (i0_rd != 5'd0) & ((i1_rs1 == i0_rd) | (i1_rs2 == i0_rd));
        issue_i0    = go & i0_valid & ~pending & rdy_01 & rdy_02;
        issue_i1    = go & i1_v & rdy_11 & rdy_12 & (pending | (issue_i0 & ~pair_raw));
        bundle_done = go & (~i0_valid | issue_i0 | pending) & (~i1_v | issue_i1);
    end

    always_comb begin
        ins_valid[0] = issue_i0 & i0_we & (i0_rd != 5'd0);
        ins_valid[1] = issue_i1 & i1_we & (i1_rd != 5'd0);
        ins_addr[0]  = ins_valid[0] ? i0_rd : 5'd0;
        ins_addr[1]  = ins_valid[1] ? i1_rd : 5'd0;
        ins_lat[0]   = !ins_valid[0] ? 2'd0 : ((i0_lat == 2'd3) ? 2'd2 : i0_lat);
        ins_lat[1]   = !ins_valid[1] ? 2'd0 : ((i1_lat == 2'd3) ? 2'd2 : i1_lat);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < 3; s++) begin
                for (int l = 0; l < 2; l++) begin
                    st_valid[s][l] <= 1'b0;
                    st_addr[s][l]  <= 5'd0;
                    st_lat[s][l]   <= 2'd0;
                end
            end
        end else if (!ex_stall) begin
            for (int l = 0; l < 2; l++) begin
                st_valid[2][l] <= st_valid[1][l];
                st_addr[2][l]  <= st_addr[1][l];
                st_lat[2][l]   <= st_lat[1][l];
                st_valid[1][l] <= st_valid[0][l];
                st_addr[1][l]  <= st_addr[0][l];
                st_lat[1][l]   <= st_lat[0][l];
                st_valid[0][l] <= ins_valid[l];
                st_addr[0][l]  <= ins_addr[l];
                st_lat[0][l]   <= ins_lat[l];
            end
        end
    end

    // A flush kills the waiting i1, so it clears pending even under a freeze.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending <= 1'b0;
        end else if (flush) begin
            pending <= 1'b0;
        end else if (!ex_stall) begin
            if (issue_i1)
                pending <= 1'b0;
            else if (issue_i0 && i1_v)
                pending <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            i0_rs1_src <= FWD_NONE;
            i0_rs2_src <= FWD_NONE;
            i1_rs1_src <= FWD_NONE;
            i1_rs2_src <= FWD_NONE;
        end else if (!ex_stall) begin
            i0_rs1_src <= issue_i0 ? src_01 : FWD_NONE;
            i0_rs2_src <= issue_i0 ? src_02 : FWD_NONE;
            i1_rs1_src <= issue_i1 ? src_11 : FWD_NONE;
            i1_rs2_src <= issue_i1 ? src_12 : FWD_NONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            stall_cnt <= '0;
        else if (i0_valid && go && !bundle_done)
            stall_cnt <= stall_cnt + 1'b1;
    end
endmodule

// File: tb/tb_issue_sched.sv
// Directed bench for issue_sched with a timestamp-based reference model of in-flight writers.

module tb_issue_sched;
    import issue_sched_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        i0_valid, i1_valid;
    logic [4:0]  i0_rs1, i0_rs2, i0_rd, i1_rs1, i1_rs2, i1_rd;
    logic        i0_we, i1_we;
    logic [1:0]  i0_lat, i1_lat;
    logic        ex_stall, flush;
    logic        issue_i0, issue_i1, bundle_done;
    fwd_src_t    i0_rs1_src, i0_rs2_src, i1_rs1_src, i1_rs2_src;
    fwd_pkt_t    ex1_fwd_p, ex2_fwd_p, ex3_fwd_p;
    logic [31:0] stall_cnt;

    int checks = 0;
    int errors = 0;

    issue_sched #(.CNT_W(32)) dut (
        .clk(clk), .rst(rst),
        .i0_valid(i0_valid), .i1_valid(i1_valid),
        .i0_rs1(i0_rs1), .i0_rs2(i0_rs2), .i0_rd(i0_rd),
        .i1_rs1(i1_rs1), .i1_rs2(i1_rs2), .i1_rd(i1_rd),
        .i0_we(i0_we), .i1_we(i1_we), .i0_lat(i0_lat), .i1_lat(i1_lat),
        .ex_stall(ex_stall), .flush(flush),
        .issue_i0(issue_i0), .issue_i1(issue_i1), .bundle_done(bundle_done),
        .i0_rs1_src(i0_rs1_src), .i0_rs2_src(i0_rs2_src),
        .i1_rs1_src(i1_rs1_src), .i1_rs2_src(i1_rs2_src),
        .ex1_fwd_p(ex1_fwd_p), .ex2_fwd_p(ex2_fwd_p), .ex3_fwd_p(ex3_fwd_p),
        .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Every issued writer is remembered with the advance count at which it issued;
    // its age in advances tells which EX stage it occupies.
    typedef struct {
        logic [4:0] rd;
        int         lane;
        int         lat;
        int         t;
    } wr_t;

    wr_t      wq[$];
    int       adv = 0;
    bit       m_pend = 0;
    int       exp_cnt = 0;
    fwd_src_t exp_src [4];

    function automatic fwd_src_t srcName(input int age, input int lane);
        case (age)
            1:       return (lane == 1) ? FWD_EX2_I1 : FWD_EX2_I0;
            2:       return (lane == 1) ? FWD_EX3_I1 : FWD_EX3_I0;
            default: return (lane == 1) ? FWD_WB_I1 : FWD_WB_I0;
        endcase
    endfunction

    function automatic void lookup(input logic [4:0] rs, output bit rdy, output fwd_src_t src);
        int best = -1;
        rdy = 1'b1;
        src = FWD_NONE;
        if (rs == 5'd0) return;
        foreach (wq[i]) begin
            int age = adv - wq[i].t;
            if (age >= 1 && age <= 3 && wq[i].rd == rs) begin
                if (best < 0 || wq[i].t > wq[best].t ||
                    (wq[i].t == wq[best].t && wq[i].lane > wq[best].lane))
                    best = i;
            end
        end
        if (best >= 0) begin
            int age = adv - wq[best].t;
            rdy = (age > wq[best].lat);
            src = srcName(age, wq[best].lane);
        end
    endfunction

    task automatic cmpPkt(input string nm, input fwd_pkt_t p, input int k);
        for (int l = 0; l < 2; l++) begin
            fwd_lane_t fl = (l == 1) ? p.i1 : p.i0;
            int        hit = -1;
            foreach (wq[i])
                if (adv - wq[i].t == k && wq[i].lane == l) hit = i;
            checkOutput($sformatf("%s_l%0d_valid", nm, l), int'(fl.valid), (hit >= 0) ? 1 : 0);
            if (hit >= 0) begin
                checkOutput($sformatf("%s_l%0d_addr", nm, l), int'(fl.addr), int'(wq[hit].rd));
                checkOutput($sformatf("%s_l%0d_ready", nm, l), int'(fl.ready), (k > wq[hit].lat) ? 1 : 0);
            end
        end
    endtask

    // Compare all outputs mid-cycle, then advance the model as the next edge will.
    always @(negedge clk) begin
        bit       r01, r02, r11, r12;
        fwd_src_t s01, s02, s11, s12;
        bit       m_go, m_i1v, m_pr, m_is0, m_is1, m_done;
        if (rst) begin
            wq.delete();
            adv     = 0;
            m_pend  = 0;
            exp_cnt = 0;
            for (int i = 0; i < 4; i++) exp_src[i] = FWD_NONE;
        end
        cmpPkt("m_ex1", ex1_fwd_p, 1);
        cmpPkt("m_ex2", ex2_fwd_p, 2);
        cmpPkt("m_ex3", ex3_fwd_p, 3);
        checkOutput("m_i0_rs1_src", int'(i0_rs1_src), int'(exp_src[0]));
        checkOutput("m_i0_rs2_src", int'(i0_rs2_src), int'(exp_src[1]));
        checkOutput("m_i1_rs1_src", int'(i1_rs1_src), int'(exp_src[2]));
        checkOutput("m_i1_rs2_src", int'(i1_rs2_src), int'(exp_src[3]));
        checkOutput("m_stall_cnt", int'(stall_cnt), exp_cnt);
        if (!rst) begin
            lookup(i0_rs1, r01, s01);
            lookup(i0_rs2, r02, s02);
            lookup(i1_rs1, r11, s11);
            lookup(i1_rs2, r12, s12);
            m_go   = !ex_stall && !flush;
            m_i1v  = i1_valid && i0_valid;
            m_pr   = i0_we && i0_rd != 0 && (i1_rs1 == i0_rd || i1_rs2 == i0_rd);
            m_is0  = m_go && i0_valid && !m_pend && r01 && r02;
            m_is1  = m_go && m_i1v && r11 && r12 && (m_pend || (m_is0 && !m_pr));
            m_done = m_go && (!i0_valid || m_is0 || m_pend) && (!m_i1v || m_is1);
            checkOutput("m_issue_i0", int'(issue_i0), int'(m_is0));
            checkOutput("m_issue_i1", int'(issue_i1), int'(m_is1));
            checkOutput("m_bundle_done", int'(bundle_done), int'(m_done));
            if (i0_valid && m_go && !m_done) exp_cnt++;
            if (flush) m_pend = 0;
            else if (!ex_stall) begin
                if (m_is1) m_pend = 0;
                else if (m_is0 && m_i1v) m_pend = 1;
            end
            if (!ex_stall) begin
                exp_src[0] = m_is0 ? s01 : FWD_NONE;
                exp_src[1] = m_is0 ? s02 : FWD_NONE;
                exp_src[2] = m_is1 ? s11 : FWD_NONE;
                exp_src[3] = m_is1 ? s12 : FWD_NONE;
                if (m_is0 && i0_we && i0_rd != 0)
                    wq.push_back('{rd: i0_rd, lane: 0, lat: (i0_lat == 3) ? 2 : int'(i0_lat), t: adv});
                if (m_is1 && i1_we && i1_rd != 0)
                    wq.push_back('{rd: i1_rd, lane: 1, lat: (i1_lat == 3) ? 2 : int'(i1_lat), t: adv});
                adv++;
                while (wq.size() > 0 && adv - wq[0].t > 3) void'(wq.pop_front());
            end
        end
    end

    // ---------------- stimulus ----------------
    typedef struct {
        logic       v;
        logic [4:0] rs1, rs2, rd;
        logic       we;
        logic [1:0] lat;
    } slot_t;

    function automatic slot_t mk(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                                 input logic [4:0] rd, input logic we, input logic [1:0] lat);
        slot_t s;
        s.v = v; s.rs1 = rs1; s.rs2 = rs2; s.rd = rd; s.we = we; s.lat = lat;
        return s;
    endfunction

    slot_t NOP;

    task automatic applyStimulus(input slot_t a, input slot_t b);
        i0_valid = a.v; i0_rs1 = a.rs1; i0_rs2 = a.rs2; i0_rd = a.rd; i0_we = a.we; i0_lat = a.lat;
        i1_valid = b.v; i1_rs1 = b.rs1; i1_rs2 = b.rs2; i1_rd = b.rd; i1_we = b.we; i1_lat = b.lat;
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        NOP = mk(0, 0, 0, 0, 0, 0);
        rst = 1'b1; ex_stall = 1'b0; flush = 1'b0;
        applyStimulus(NOP, NOP);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_stall_cnt", int'(stall_cnt), 0);
        checkOutput("rst_ex1_valid", int'(ex1_fwd_p.i0.valid), 0);
        checkOutput("rst_i0_rs1_src", int'(i0_rs1_src), int'(FWD_NONE));
        rst = 1'b0;

        // independent pair issues together
        applyStimulus(mk(1, 1, 2, 5, 1, 0), mk(1, 3, 4, 6, 1, 0));
        checkOutput("s1_issue_i0", int'(issue_i0), 1);
        checkOutput("s1_issue_i1", int'(issue_i1), 1);
        checkOutput("s1_done", int'(bundle_done), 1);
        step(); applyStimulus(NOP, NOP);
        checkOutput("s1_ex1_i0_addr", int'(ex1_fwd_p.i0.addr), 5);
        checkOutput("s1_ex1_i0_ready", int'(ex1_fwd_p.i0.ready), 1);
        checkOutput("s1_ex1_i1_addr", int'(ex1_fwd_p.i1.addr), 6);
        checkOutput("s1_ex1_i1_ready", int'(ex1_fwd_p.i1.ready), 1);

        // load-use on a latency-2 producer
        applyStimulus(mk(1, 0, 0, 7, 1, 2), NOP);
        checkOutput("s2_lw_issue", int'(issue_i0), 1);
        step(); applyStimulus(mk(1, 7, 0, 8, 1, 0), NOP);
        checkOutput("s2_stall1", int'(issue_i0), 0);
        checkOutput("s2_stall1_done", int'(bundle_done), 0);
        step();
        checkOutput("s2_stall2", int'(issue_i0), 0);
        step();
        checkOutput("s2_issue", int'(issue_i0), 1);
        step(); applyStimulus(NOP, NOP);
        checkOutput("s2_src", int'(i0_rs1_src), int'(FWD_WB_I0));
        checkOutput("s2_cnt", int'(stall_cnt), 2);

        // same-bundle RAW splits the pair
        applyStimulus(mk(1, 0, 0, 9, 1, 0), mk(1, 9, 0, 10, 1, 0));
        checkOutput("s3_c1_i0", int'(issue_i0), 1);
        checkOutput("s3_c1_i1", int'(issue_i1), 0);
        checkOutput("s3_c1_done", int'(bundle_done), 0);
        step();
        checkOutput("s3_c2_i0", int'(issue_i0), 0);
        checkOutput("s3_c2_i1", int'(issue_i1), 1);
        checkOutput("s3_c2_done", int'(bundle_done), 1);
        step(); applyStimulus(NOP, NOP);
        checkOutput("s3_src", int'(i1_rs1_src), int'(FWD_EX2_I0));
        checkOutput("s3_cnt", int'(stall_cnt), 3);

        // backend freeze holds everything
        applyStimulus(mk(1, 0, 0, 5, 1, 0), NOP);
        step();
        ex_stall = 1'b1;
        applyStimulus(mk(1, 5, 0, 0, 0, 0), NOP);
        for (int i = 0; i < 3; i++) begin
            checkOutput("s4_no_issue", int'(issue_i0), 0);
            checkOutput("s4_ex1_addr", int'(ex1_fwd_p.i0.addr), 5);
            checkOutput("s4_cnt", int'(stall_cnt), 3);
            step();
        end
        ex_stall = 1'b0;
        applyStimulus(mk(1, 5, 0, 0, 0, 0), NOP);
        checkOutput("s4_release_issue", int'(issue_i0), 1);
        step(); applyStimulus(NOP, NOP);
        checkOutput("s4_ex2_addr", int'(ex2_fwd_p.i0.addr), 5);
        checkOutput("s4_src", int'(i0_rs1_src), int'(FWD_EX2_I0));

        // flush while i1 is pending
        applyStimulus(mk(1, 0, 0, 11, 1, 0), mk(1, 11, 0, 12, 1, 0));
        checkOutput("s5_i1_held", int'(issue_i1), 0);
        step();
        flush = 1'b1;
        applyStimulus(mk(1, 0, 0, 11, 1, 0), mk(1, 11, 0, 12, 1, 0));
        checkOutput("s5_flush_i1", int'(issue_i1), 0);
        checkOutput("s5_flush_done", int'(bundle_done), 0);
        step();
        flush = 1'b0;
        applyStimulus(NOP, NOP);
        checkOutput("s5_ex1_bubble", int'(ex1_fwd_p.i0.valid), 0);
        checkOutput("s5_ex2_addr", int'(ex2_fwd_p.i0.addr), 11);
        checkOutput("s5_cnt", int'(stall_cnt), 4);
        applyStimulus(mk(1, 0, 0, 13, 1, 1), NOP);
        checkOutput("s5_pend_clear", int'(issue_i0), 1);

        // latency-1 producer forwards from EX2
        step(); applyStimulus(mk(1, 13, 0, 14, 1, 0), NOP);
        checkOutput("l1_stall", int'(issue_i0), 0);
        step();
        checkOutput("l1_issue", int'(issue_i0), 1);
        step(); applyStimulus(NOP, NOP);
        checkOutput("l1_src", int'(i0_rs1_src), int'(FWD_EX3_I0));
        checkOutput("l1_cnt", int'(stall_cnt), 5);

        // both lanes write x3: i1 is the younger producer
        applyStimulus(mk(1, 0, 0, 3, 1, 0), mk(1, 0, 0, 3, 1, 0));
        checkOutput("s6_pair_issue", int'(issue_i1), 1);
        step(); applyStimulus(mk(1, 3, 0, 0, 0, 0), NOP);
        checkOutput("s6_consumer", int'(issue_i0), 1);
        step(); applyStimulus(NOP, NOP);
        checkOutput("s6_src", int'(i0_rs1_src), int'(FWD_EX2_I1));

        // x0 writes are never tracked; lat 3 behaves as lat 2
        applyStimulus(mk(1, 0, 0, 0, 1, 2), NOP);
        checkOutput("x0_issue", int'(issue_i0), 1);
        step(); applyStimulus(mk(1, 0, 0, 15, 1, 3), NOP);
        checkOutput("x0_not_tracked", int'(ex1_fwd_p.i0.valid), 0);
        checkOutput("x0_consumer", int'(issue_i0), 1);
        step(); applyStimulus(mk(1, 15, 15, 0, 0, 0), NOP);
        checkOutput("l3_stall1", int'(issue_i0), 0);
        step();
        checkOutput("l3_stall2", int'(issue_i0), 0);
        step();
        checkOutput("l3_issue", int'(issue_i0), 1);
        step(); applyStimulus(NOP, NOP);
        checkOutput("l3_src", int'(i0_rs2_src), int'(FWD_WB_I0));
        checkOutput("l3_cnt", int'(stall_cnt), 7);

        // asynchronous reset mid-flight
        applyStimulus(mk(1, 0, 0, 20, 1, 0), NOP);
        step(); applyStimulus(NOP, NOP);
        checkOutput("mr_before", int'(ex1_fwd_p.i0.valid), 1);
        #1 rst = 1'b1;
        #1;
        checkOutput("mr_ex1_cleared", int'(ex1_fwd_p.i0.valid), 0);
        checkOutput("mr_cnt", int'(stall_cnt), 0);
        step();
        rst = 1'b0;
        repeat (3) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
